// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction-fetch request unit.
// Optional feature macro: PC_EPC_EN enables the EPC register and exception-return path.
module pc_fetch_unit #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = 32'h8000_fff0,
  parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h8000_0180
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_en,
  input  logic              br_valid,
  input  logic [ADDR_W-3:0] br_target,
  input  logic              exc_valid,
  input  logic [ADDR_W-3:0] exc_pc,
  input  logic              eret_valid,
  input  logic              imem_ack,
  output logic              imem_req,
  output logic [ADDR_W-3:0] imem_addr,
  output logic [ADDR_W-3:0] pc_out,
  output logic              pc_work,
  output logic              fetch_valid,
  output logic              redirect_pending,
  output logic [ADDR_W-3:0] epc_out
);

  localparam int              PC_W     = ADDR_W - 2;
  localparam logic [PC_W-1:0] RESET_PC = RESET_VEC[ADDR_W-1:2];
  localparam logic [PC_W-1:0] EXC_PC   = EXC_VEC[ADDR_W-1:2];

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t            state_r;
  logic [PC_W-1:0]   pend_target_r;
  logic              pend_exc_r;
  logic              eret_s;
  logic              redir_s;
  logic              keep_pend_s;
  logic [PC_W-1:0]   redir_target_s;
  logic [PC_W-1:0]   next_pc_s;

`ifdef PC_EPC_EN
  assign eret_s = eret_valid;

  // EPC capture on every exception strobe outside reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      epc_out <= {PC_W{1'b0}};
    end else if (exc_valid) begin
      epc_out <= exc_pc;
    end else begin
      epc_out <= epc_out;
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{exc_pc, eret_valid};
  assign eret_s   = 1'b0;
  assign epc_out  = {PC_W{1'b0}};
`endif

  assign imem_addr = pc_out;
  assign redir_s   = exc_valid | eret_s | br_valid;
  // A buffered exception is only displaced by another exception.
  assign keep_pend_s = redirect_pending & pend_exc_r & ~exc_valid;

  // Redirect target and next-PC priority selection
  always_comb begin
    redir_target_s = br_target;
    if (exc_valid) begin
      redir_target_s = EXC_PC;
    end else if (eret_s) begin
      redir_target_s = epc_out;
    end else begin
      redir_target_s = br_target;
    end

    next_pc_s = pc_out + {{(PC_W-1){1'b0}}, 1'b1};
    if (redir_s) begin
      next_pc_s = redir_target_s;
    end else if (redirect_pending) begin
      next_pc_s = pend_target_r;
    end else begin
      next_pc_s = pc_out + {{(PC_W-1){1'b0}}, 1'b1};
    end
  end

  // Fetch FSM with PC, handshake and redirect buffer state
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r          <= BOOT;
      pc_out           <= RESET_PC;
      pc_work          <= 1'b0;
      imem_req         <= 1'b0;
      fetch_valid      <= 1'b0;
      redirect_pending <= 1'b0;
      pend_target_r    <= {PC_W{1'b0}};
      pend_exc_r       <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      case (state_r)
        BOOT: begin
          state_r  <= pc_en ? FETCH : STALL;
          imem_req <= pc_en;
        end
        FETCH: begin
          if (imem_ack) begin
            pc_out           <= next_pc_s;
            pc_work          <= ~pc_work;
            fetch_valid      <= 1'b1;
            redirect_pending <= 1'b0;
            pend_exc_r       <= 1'b0;
            state_r          <= pc_en ? FETCH : STALL;
            imem_req         <= pc_en;
          end else if (redir_s && !keep_pend_s) begin
            pend_target_r    <= redir_target_s;
            pend_exc_r       <= exc_valid;
            redirect_pending <= 1'b1;
          end else begin
            redirect_pending <= redirect_pending;
          end
        end
        STALL: begin
          if (redir_s) begin
            pc_out <= next_pc_s;
          end else begin
            pc_out <= pc_out;
          end
          redirect_pending <= 1'b0;
          pend_exc_r       <= 1'b0;
          if (pc_en) begin
            state_r  <= FETCH;
            imem_req <= 1'b1;
          end else begin
            state_r  <= STALL;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state_r  <= BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised program-counter and fetch-request unit at the head of the instruction-fetch stage. Holds the word-aligned PC, issues one instruction-memory request at a time with a req/ack handshake, and selects the next PC by fixed priority among exception, exception-return, branch and sequential increment. Redirects that arrive while a request is outstanding are buffered so the request address stays stable.

## Interface
- ADDR_W, 32: byte-address width; the PC holds bits [ADDR_W-1:2].
- RESET_VEC, 32'h8000_fff0: byte address loaded on reset.
- EXC_VEC, 32'h8000_0180: byte address taken on exception.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- pc_en  in  1  fetch enable; 0 = stall new requests.
- br_valid  in  1  branch/jump redirect strobe.
- br_target  in  ADDR_W-2  branch target word address.
- exc_valid  in  1  exception strobe.
- exc_pc  in  ADDR_W-2  faulting word address, captured into EPC.
- eret_valid  in  1  exception-return strobe.
- imem_ack  in  1  instruction memory accepted/completed current request.
- imem_req  out  1  request valid.
- imem_addr  out  ADDR_W-2  request word address; always equals pc_out.
- pc_out  out  ADDR_W-2  current PC.
- pc_work  out  1  toggles once per completed fetch.
- fetch_valid  out  1  one-cycle pulse the cycle after an ack.
- redirect_pending  out  1  a buffered redirect is waiting.
- epc_out  out  ADDR_W-2  exception PC.

## Operation
- States: BOOT, FETCH, STALL.
- Reset (reset=0): pc_out=RESET_VEC>>2, pc_work=0, imem_req=0, fetch_valid=0, redirect_pending=0, pend_target=0, epc_out=0, state=BOOT.
- BOOT: imem_req=0; next cycle -> FETCH if pc_en=1, else STALL.
- FETCH: imem_req=1, imem_addr=pc_out held constant until ack.
  - No ack: any redirect strobe is written to pend_target (exc -> EXC_VEC>>2, eret -> epc_out, br -> br_target), redirect_pending=1; later redirect overwrites earlier unless the buffered one is an exception and the new one is not.
  - Ack: pc_out <= next_pc, pc_work toggles, fetch_valid=1 next cycle, redirect_pending cleared; -> FETCH if pc_en=1, else STALL. Ack is honoured even when pc_en=0 (request cannot be withdrawn).
- STALL: imem_req=0; redirect strobes load pc_out directly via next_pc priority, pending cleared; pc_en=1 -> FETCH.
- next_pc priority: exc_valid > eret_valid > br_valid > redirect_pending > pc_out+1.
- Increment wraps modulo 2^(ADDR_W-2); 0x3FFF_FFFF+1 = 0x0000_0000 for ADDR_W=32.
- exc_valid in any non-reset state: epc_out <= exc_pc same edge.
- imem_ack outside FETCH ignored.

## Timing
- Request latency from reset release: imem_req high on 2nd edge after reset=1 (BOOT one cycle).
- Back-to-back: ack in cycle N -> new imem_addr and imem_req=1 in cycle N+1; max throughput one fetch per cycle with ack held high.
- fetch_valid asserted exactly cycle N+1 for ack in cycle N; pc_work toggles at the same edge.
- Redirect coincident with ack takes effect on that ack (no pending stage); redirect without ack appears on imem_addr the cycle after the eventual ack.
- Reset mid-request: imem_req=0 the cycle after reset sampled low, regardless of imem_ack.

## Configuration
- PC_EPC_EN defined: EPC register and eret path present as described.
- PC_EPC_EN undefined: eret_valid ignored (not in priority, not buffered), epc_out tied to 0, exc_pc unused; exception redirect to EXC_VEC unchanged.

## Test plan
- Reset then pc_en=1, ack held 1: imem_addr sequence 0x20003FFC, 0x20003FFD, 0x20003FFE; pc_work 0,1,0,1; fetch_valid high from cycle after first ack.
- Request at 0x2000_0010, ack delayed 3 cycles, br_valid with target 0x2000_0100 in wait cycle 1: imem_addr stays 0x2000_0010, redirect_pending=1, after ack imem_addr=0x2000_0100.
- Same cycle exc_valid, br_valid and ack, exc_pc=0x2000_0020: next imem_addr=0x2000_0060 (EXC_VEC>>2), epc_out=0x2000_0020.
- With PC_EPC_EN: after above, eret_valid with ack -> imem_addr 0x2000_0020; without macro: eret ignored, sequential 0x2000_0061.
- pc_en=0 during outstanding request, ack arrives: pc_out advances once, STALL, imem_req=0 until pc_en=1; br in STALL loads pc_out immediately.
- pc_out=0x3FFF_FFFF, ack -> 0x0000_0000; reset=0 during outstanding request -> imem_req=0 next cycle, pc_out=0x20003FFC.
